regfile_arbiter: RTL
====================

# regfile_arbiter

Round-robin access controller that shares a bank of 2**AW 32-bit enable-loaded registers between NREQ requesters. Each requester issues single read or write transactions over a req/ack handshake. The controller drives the bank's per-register load enables and a shared write-data bus, and returns read data. It sits between the host-side masters and the register-bank instances in the datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 3, register address width; bank holds NREG = 2**AW registers
- DW, 32, data width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester transaction request
- we  in  NREQ  per-requester write(1)/read(0) qualifier
- addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- ack  out  NREQ  one-cycle completion strobe, at most one bit set
- rdata  out  DW  read data, valid only while ack is high
- reg_en  out  NREG  one-hot load enable to bank register k
- reg_din  out  DW  shared write data to all bank registers
- reg_dout  in  NREG*DW  packed bank outputs, register k at [k*DW +: DW]
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, XFER, ACK; reset state IDLE.
- IDLE:
  - If any req bit is set, grant one requester, latch its index, addr and we, then go to XFER.
  - Otherwise stay in IDLE.
- Arbitration: round-robin pointer ptr (reset 0). Search req from ptr upward, wrapping at NREQ; first set bit wins. After a grant to g, ptr = (g+1) mod NREQ.
- Entering XFER on a write: reg_en = one-hot(addr_q) and reg_din = wdata[g], both registered. On a read: reg_en = 0.
- XFER lasts exactly one cycle, then the state goes to ACK. The bank captures the write at the XFER→ACK edge.
- Entering ACK: ack[g] = 1 and reg_en = 0.
  - Read: rdata = reg_dout[addr_q], sampled at that edge.
  - Write: rdata = the written data.
- ACK → IDLE unconditionally. req is ignored in XFER and ACK.
- Requester rules:
  - req, we, addr and wdata are held stable from assertion until ack is seen.
  - req is dropped no later than the edge that ends the ack cycle.
- All registered outputs reset to 0: ack, rdata, reg_en, reg_din, busy. ptr resets to 0.
- Reset asserted mid-transaction: all outputs go to 0 immediately and asynchronously. An in-flight write whose reg_en has not yet been sampled is lost; requesters must reissue.

## Timing
- Request sampled at edge E0 (state IDLE): XFER and reg_en active E0–E1; write lands in the bank at E1; ack and rdata valid E1–E2; IDLE from E2.
- Latency from the req sample edge to ack high: 1 cycle.
- Peak throughput: one transaction per 3 cycles.
- Next grant is no earlier than the sample edge E3.
- Read-after-write by a different requester returns the new value.
- busy is high in cycles E0–E2 and low in IDLE.

## Configuration
- Macro: REGARB_LOCK_EN.
- Defined:
  - Adds input port lock (NREQ bits).
  - If lock[g] is high during g's ACK cycle, the controller keeps ownership: the next IDLE grants only g (if req[g]), ptr does not advance, and others are held off.
  - Ownership ends when g completes a transaction with lock[g] low, or when g is idle for one IDLE cycle with req[g] low.
- Undefined: no lock port; pure round-robin as above.

## Test plan
- Single write then read:
  - Stimulus: req[0] write addr 3 data 32'hDEADBEEF, then req[0] read addr 3.
  - Response: reg_en = 8'b0000_1000 for one cycle; ack[0] at E1; read rdata = 32'hDEADBEEF.
- All four requesters assert req simultaneously from reset.
  - Response: grants in order 0,1,2,3, one ack each, 3 cycles apart.
  - ptr wraps; a fifth req[0] is granted after requester 3.
- Write/read race:
  - Stimulus: requester 1 writes addr 5 = 32'h1234_5678; requester 2 reads addr 5, queued behind it.
  - Response: requester 2 gets 32'h1234_5678.
- Reset mid-operation:
  - Stimulus: assert rst low during XFER of a write to addr 2.
  - Response: reg_en, ack and busy go to 0 immediately; FSM is IDLE after release; ptr = 0.
- Back-to-back requests:
  - Stimulus: req held across the ack cycle, then dropped at E2.
  - Response: exactly one ack; no duplicate transaction.
- With REGARB_LOCK_EN defined:
  - Stimulus: requester 2 holds lock for 3 writes while requester 0 requests.
  - Response: requester 0 receives no ack until the lock is released; it is granted next.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin req/ack controller sharing a 2**AW-entry register bank.
// Ports: clk, rst (asynchronous, active-low); per-requester req/we/addr/wdata in, ack/rdata out;
//        bank side reg_en (one-hot load), reg_din (shared write data), reg_dout (packed bank outputs);
//        busy high outside IDLE. Define REGARB_LOCK_EN to add lock[NREQ] for bus ownership.
module regfile_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*AW-1:0]     addr,
  input  logic [NREQ*DW-1:0]     wdata,
`ifdef REGARB_LOCK_EN
  input  logic [NREQ-1:0]        lock,
`endif
  output logic [NREQ-1:0]        ack,
  output logic [DW-1:0]          rdata,
  output logic [(2**AW)-1:0]     reg_en,
  output logic [DW-1:0]          reg_din,
  input  logic [(2**AW)*DW-1:0]  reg_dout,
  output logic                   busy
);
  localparam int NREG = 2**AW;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;
  state_t state, state_d;
  logic [PW-1:0] ptr, ptr_nx, gnt_rr, gnt, g_q, idx;
  logic [PW:0] sum;
  logic found, go, adv, we_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] wdata_a [NREQ];
  logic [DW-1:0] dout_a [NREG];
  always_comb
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = addr[i*AW +: AW];
      wdata_a[i] = wdata[i*DW +: DW];
    end
  always_comb
    for (int k = 0; k < NREG; k++) dout_a[k] = reg_dout[k*DW +: DW];
  // first requesting index at or above ptr, wrapping at NREQ
  always_comb begin
    found = 1'b0;
    gnt_rr = '0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      idx = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt_rr = idx;
      end
    end
  end
`ifdef REGARB_LOCK_EN
  logic own_v;
  logic [PW-1:0] own;
  // an owner locks out everyone else and freezes the pointer
  assign gnt = own_v ? own : gnt_rr;
  assign go = own_v ? req[own] : found;
  assign adv = !own_v;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      own_v <= 1'b0;
      own <= '0;
    end else if (state == ACK) begin
      own_v <= lock[g_q];
      own <= g_q;
    end else if (state == IDLE && own_v && !req[own]) begin
      own_v <= 1'b0;
    end
`else
  assign gnt = gnt_rr;
  assign go = found;
  assign adv = 1'b1;
`endif
  assign ptr_nx = (gnt == PW'(NREQ-1)) ? '0 : gnt + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;
  always_comb
    state_d = (state == IDLE) ? (go ? XFER : IDLE) : (state == XFER) ? ACK : IDLE;
  always_comb busy = (state != IDLE);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {ptr, g_q, addr_q, we_q, ack, rdata, reg_en, reg_din} <= '0;
    end else begin
      ack <= '0;
      if (state == IDLE && go) begin
        g_q <= gnt;
        addr_q <= addr_a[gnt];
        we_q <= we[gnt];
        reg_en <= we[gnt] ? NREG'(1) << addr_a[gnt] : '0;
        reg_din <= wdata_a[gnt];
        if (adv) ptr <= ptr_nx;
      end
      // bank captures reg_din on this same edge, so a write echoes reg_din
      if (state == XFER) begin
        ack[g_q] <= 1'b1;
        reg_en <= '0;
        rdata <= we_q ? reg_din : dout_a[addr_q];
      end
    end
endmodule
